// File: rtl/control_unit.sv
// RV32I main decoder: combinational decode of opcode/funct fields and branch
// flags, registered once so every control output appears one clk edge later.

package control_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SLT    = 4'b0011,
    ALU_SLTU   = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       less_than,
  input  logic       less_than_unsigned,
  input  logic       greater_than,
  input  logic       greater_than_or_equal,
  input  logic       greater_than_or_equal_unsigned,
  output logic [3:0] ALUOp,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       branch,
  output logic       ALUSrc
);

  ctrl_t ctrl_d, ctrl_q;

  // greater_than and funct7 bits other than 5 carry no meaning for this decoder.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, greater_than, funct7[6], funct7[4:0]};

  // Shared R/I-type funct3 map; alt selects SUB/SRA where the caller allows it.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic branch_taken;
  logic branch_f3_ok;

  always_comb begin
    branch_taken = 1'b0;
    branch_f3_ok = 1'b1;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = less_than;
      3'b101:  branch_taken = greater_than_or_equal;
      3'b110:  branch_taken = less_than_unsigned;
      3'b111:  branch_taken = greater_than_or_equal_unsigned;
      default: branch_f3_ok = 1'b0;
    endcase
  end

  // NOTE: ctrl_d takes the all-zero default before the case so that every
  // path assigns every field; a missing assignment here would infer a latch.
  always_comb begin
    ctrl_d = CTRL_NOP;
    case (opcode)
      OP_R: begin
        ctrl_d.alu_op    = alu_from_funct3(funct3, funct7[5]);
        ctrl_d.reg_write = 1'b1;
      end
      OP_I: begin
        ctrl_d.alu_op    = alu_from_funct3(funct3, funct7[5] && (funct3 == 3'b101));
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_LOAD: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          ctrl_d.alu_op    = ALU_ADD;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.mem_read  = 1'b1;
          ctrl_d.alu_src   = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
          ctrl_d.alu_op    = ALU_ADD;
          ctrl_d.mem_write = 1'b1;
          ctrl_d.alu_src   = 1'b1;
        end
      end
      OP_BRANCH: begin
        // funct3 010/011 are not RV32I branches and decode as a bubble.
        if (branch_f3_ok) begin
          ctrl_d.alu_op = ALU_SUB;
          ctrl_d.branch = branch_taken;
        end
      end
      OP_LUI: begin
        ctrl_d.alu_op    = ALU_PASS_B;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_AUIPC: begin
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_JAL: begin
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.branch    = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          ctrl_d.alu_op    = ALU_ADD;
          ctrl_d.reg_write = 1'b1;
          ctrl_d.branch    = 1'b1;
          ctrl_d.alu_src   = 1'b1;
        end
      end
      default: ctrl_d = CTRL_NOP;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of ctrl_d regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ALUOp    = ctrl_q.alu_op;
  assign RegWrite = ctrl_q.reg_write;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign branch   = ctrl_q.branch;
  assign ALUSrc   = ctrl_q.alu_src;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected control words are queued when
// an instruction is driven and compared one edge later.

module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, lt, ltu, gt, ge, geu;
  logic [3:0] ALUOp;
  logic       RegWrite, MemRead, MemWrite, branch, ALUSrc;

  int n_checks = 0;
  int n_errors = 0;

  // Expected word layout: {ALUOp[3:0], RegWrite, MemRead, MemWrite, branch, ALUSrc}
  logic [8:0] exp_q[$];

  control_unit dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .opcode                        (opcode),
    .funct3                        (funct3),
    .funct7                        (funct7),
    .zero                          (zero),
    .less_than                     (lt),
    .less_than_unsigned            (ltu),
    .greater_than                  (gt),
    .greater_than_or_equal         (ge),
    .greater_than_or_equal_unsigned(geu),
    .ALUOp                         (ALUOp),
    .RegWrite                      (RegWrite),
    .MemRead                       (MemRead),
    .MemWrite                      (MemWrite),
    .branch                        (branch),
    .ALUSrc                        (ALUSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] dut_word();
    return {ALUOp, RegWrite, MemRead, MemWrite, branch, ALUSrc};
  endfunction

  // Reference decoder written as table lookups.
  function automatic logic [8:0] model(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [5:0] fl);
    logic [3:0] rmap [8];
    logic [3:0] a;
    logic z, l, lu, g, gu;
    rmap = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    {z, l, lu, g, gu} = {fl[5], fl[4], fl[3], fl[1], fl[0]};
    a = rmap[f3];
    case (op)
      7'b0110011: begin
        if (f7[5] && f3 == 3'd0) a = 4'd1;
        if (f7[5] && f3 == 3'd5) a = 4'd7;
        return {a, 5'b10000};
      end
      7'b0010011: begin
        if (f7[5] && f3 == 3'd5) a = 4'd7;
        return {a, 5'b10001};
      end
      7'b0000011: return (f3 == 3 || f3 > 5) ? 9'd0 : {4'd0, 5'b11001};
      7'b0100011: return (f3 > 2) ? 9'd0 : {4'd0, 5'b00101};
      7'b1100011: begin
        case (f3)
          3'd0: return {4'd1, 2'b00, 1'b0, z, 1'b0};
          3'd1: return {4'd1, 2'b00, 1'b0, !z, 1'b0};
          3'd4: return {4'd1, 2'b00, 1'b0, l, 1'b0};
          3'd5: return {4'd1, 2'b00, 1'b0, g, 1'b0};
          3'd6: return {4'd1, 2'b00, 1'b0, lu, 1'b0};
          3'd7: return {4'd1, 2'b00, 1'b0, gu, 1'b0};
          default: return 9'd0;
        endcase
      end
      7'b0110111: return {4'd10, 5'b10001};
      7'b0010111: return {4'd0, 5'b10001};
      7'b1101111: return {4'd0, 5'b10010};
      7'b1100111: return (f3 == 3'd0) ? {4'd0, 5'b10011} : 9'd0;
      default:    return 9'd0;
    endcase
  endfunction

  // fl = {zero, lt, ltu, gt, ge, geu}
  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [5:0] fl);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    {zero, lt, ltu, gt, ge, geu} = fl;
  endtask

  task automatic apply(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [5:0] fl);
    logic [8:0] exp;
    @(negedge clk);
    drive(op, f3, f7, fl);
    exp_q.push_back(model(op, f3, f7, fl));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, dut_word(), 9'h1ff);
    end else begin
      exp = exp_q.pop_front();
      check(tag, dut_word(), exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(7'b0110111, 3'd0, 7'd0, 6'd0);
    #1;
    check("reset_async", dut_word(), 9'd0);
    #6;
    check("reset_edge", dut_word(), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    apply("r_sub",      7'b0110011, 3'b000, 7'b0100000, 6'd0);
    apply("r_add",      7'b0110011, 3'b000, 7'b0000000, 6'd0);
    apply("r_xor_f7",   7'b0110011, 3'b100, 7'b0100000, 6'd0);
    apply("r_sra",      7'b0110011, 3'b101, 7'b0100000, 6'd0);
    apply("r_and",      7'b0110011, 3'b111, 7'b0000000, 6'd0);
    apply("i_srai",     7'b0010011, 3'b101, 7'b0100000, 6'd0);
    apply("i_no_subi",  7'b0010011, 3'b000, 7'b0100000, 6'd0);
    apply("i_slli_f7",  7'b0010011, 3'b001, 7'b0100000, 6'd0);
    apply("load_lw",    7'b0000011, 3'b010, 7'd0, 6'd0);
    apply("load_bad",   7'b0000011, 3'b011, 7'd0, 6'd0);
    apply("store_sw",   7'b0100011, 3'b010, 7'd0, 6'd0);
    apply("store_bad",  7'b0100011, 3'b011, 7'd0, 6'd0);
    apply("beq_taken",  7'b1100011, 3'b000, 7'd0, 6'b100000);
    apply("bne_zero",   7'b1100011, 3'b001, 7'd0, 6'b100000);
    apply("bltu_taken", 7'b1100011, 3'b110, 7'd0, 6'b001000);
    apply("br_f3_010",  7'b1100011, 3'b010, 7'd0, 6'b111111);
    apply("bge_gt_only",7'b1100011, 3'b101, 7'd0, 6'b000100);
    apply("bge_taken",  7'b1100011, 3'b101, 7'd0, 6'b000010);
    apply("lui",        7'b0110111, 3'b011, 7'd0, 6'd0);
    apply("auipc",      7'b0010111, 3'b000, 7'd0, 6'd0);
    apply("jal",        7'b1101111, 3'b000, 7'd0, 6'd0);
    apply("jalr",       7'b1100111, 3'b000, 7'd0, 6'd0);
    apply("jalr_bad",   7'b1100111, 3'b001, 7'd0, 6'd0);
    apply("bad_opcode", 7'b1111111, 3'b000, 7'd0, 6'd0);

    // Mid-stream reset: outputs must clear without any clock edge.
    apply("pre_reset",  7'b0110111, 3'b000, 7'd0, 6'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_async", dut_word(), 9'd0);
    @(posedge clk);
    #1;
    check("reset_mid_hold", dut_word(), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(7'b1101111, 3'd0, 7'd0, 6'd0);
    exp_q.push_back(model(7'b1101111, 3'd0, 7'd0, 6'd0));
    #1;
    check("reset_release_wait", dut_word(), 9'd0);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check("post_reset_sb_empty", dut_word(), 9'h1ff);
    else check("post_reset_jal", dut_word(), exp_q.pop_front());

    // Random stimulus biased toward valid opcodes.
    for (int i = 0; i < 300; i++) begin
      logic [6:0] ops [10];
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [5:0] fl;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000000};
      op = ops[$urandom_range(0, 9)];
      if (op == 7'b0000000) op = 7'($urandom);
      f3 = 3'($urandom);
      f7 = 7'($urandom);
      fl = 6'($urandom);
      apply("rand", op, f3, f7, fl);
      check("mem_excl", {8'd0, MemRead & MemWrite}, 9'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
